// File: rtl/simd_pkg.sv
// Shared constants and FSM encoding for the SIMD stream controller.
package simd_pkg;

  localparam int unsigned ELEM_W_DFLT = 21;
  localparam int unsigned N_ELEM      = 16;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned LAT_W       = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    COMPUTE = 3'd3,
    CAPTURE = 3'd4,
    DRAIN   = 3'd5
  } state_t;

  // States in which the input stream may transfer an element.
  function automatic logic accepts_input(input state_t s);
    return (s == IDLE) || (s == LOAD_A) || (s == LOAD_B);
  endfunction

endpackage

// File: rtl/elem_shift_reg.sv
// Result register: parallel load of a packed matrix, serial unload of the MSB slot first.
module elem_shift_reg
  import simd_pkg::*;
#(
  parameter int unsigned ELEM_W = ELEM_W_DFLT,
  parameter int unsigned DEPTH  = N_ELEM
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic                      shift,
  input  logic [DEPTH*ELEM_W-1:0]   par_data,
  output logic [ELEM_W-1:0]         head
);

  localparam int unsigned TOT_W = DEPTH * ELEM_W;

  logic [TOT_W-1:0] data_q;

  // Zeros shift in behind the unloaded elements, so a drained register holds no stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= par_data;
    end else if (shift) begin
      data_q <= {data_q[TOT_W-ELEM_W-1:0], {ELEM_W{1'b0}}};
    end
  end

  assign head = data_q[TOT_W-1 -: ELEM_W];

endmodule

// File: rtl/simd_stream_ctrl.sv
// Streams 16 A + 16 B elements into a SIMD array, runs it for LAT cycles,
// then streams the 16 result elements back out.
module simd_stream_ctrl
  import simd_pkg::*;
#(
  parameter int unsigned ELEM_W = ELEM_W_DFLT,
  parameter int unsigned LAT    = 2
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ELEM_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ELEM_W-1:0]          out_data,
  output logic                       busy,
  output logic [N_ELEM*ELEM_W-1:0]   Matrix_A,
  output logic [N_ELEM*ELEM_W-1:0]   Matrix_B,
  output logic                       enable,
  input  logic [N_ELEM*ELEM_W-1:0]   Matrix_C
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LAT_W-1:0] lat_q, lat_d;

  logic in_ready_q, out_valid_q, enable_q, busy_q;
  logic in_fire, out_fire, last_elem, cap_load;

  logic [ELEM_W-1:0] mat_a_q [N_ELEM];
  logic [ELEM_W-1:0] mat_b_q [N_ELEM];

  assign in_fire   = in_valid & in_ready_q;
  assign out_fire  = out_valid_q & out_ready;
  assign last_elem = (cnt_q == CNT_W'(N_ELEM - 1));

  // Next-state, counter and capture-strobe logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lat_d    = lat_q;
    cap_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          state_d = LOAD_A;
          cnt_d   = CNT_W'(1);
        end
      end
      LOAD_A: begin
        if (in_fire) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_elem) state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (in_fire) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_elem) begin
            state_d = COMPUTE;
            lat_d   = '0;
          end
        end
      end
      COMPUTE: begin
        if (lat_q == LAT_W'(LAT - 1)) begin
          state_d = CAPTURE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      CAPTURE: begin
        cap_load = 1'b1;
        cnt_d    = '0;
        state_d  = DRAIN;
      end
      DRAIN: begin
        if (out_fire) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_elem) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and outputs are registered from the next state so they line up with it cycle-exactly.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lat_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      enable_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
      in_ready_q  <= accepts_input(state_d);
      out_valid_q <= (state_d == DRAIN);
      enable_q    <= (state_d == COMPUTE);
      busy_q      <= (state_d != IDLE);
    end
  end

  // Operand load path; slots hold their value until overwritten by the next job.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      mat_a_q <= '{default: '0};
      mat_b_q <= '{default: '0};
    end else if (in_fire) begin
      if (state_q == LOAD_B) begin
        mat_b_q[cnt_q] <= in_data;
      end else begin
        mat_a_q[cnt_q] <= in_data;
      end
    end
  end

  for (genvar k = 0; k < N_ELEM; k++) begin : g_pack
    assign Matrix_A[(N_ELEM-1-k)*ELEM_W +: ELEM_W] = mat_a_q[k];
    assign Matrix_B[(N_ELEM-1-k)*ELEM_W +: ELEM_W] = mat_b_q[k];
  end

  elem_shift_reg #(
    .ELEM_W (ELEM_W),
    .DEPTH  (N_ELEM)
  ) u_result (
    .clk      (CLK),
    .rst_n    (reset),
    .load     (cap_load),
    .shift    (out_fire),
    .par_data (Matrix_C),
    .head     (out_data)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign enable    = enable_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_simd_stream_ctrl.sv
// Directed bench for simd_stream_ctrl with a behavioural 4x4 matrix-multiply SIMD array.
module tb_simd_stream_ctrl;

  localparam int unsigned W   = 21;
  localparam int unsigned N   = 16;
  localparam int unsigned MW  = N * W;
  localparam int unsigned LAT = 2;

  typedef logic [MW-1:0] mat_t;

  logic          CLK;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          busy;
  mat_t          Matrix_A;
  mat_t          Matrix_B;
  logic          enable;
  mat_t          Matrix_C;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] sb[$];

  simd_stream_ctrl #(.ELEM_W(W), .LAT(LAT)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .Matrix_A  (Matrix_A),
    .Matrix_B  (Matrix_B),
    .enable    (enable),
    .Matrix_C  (Matrix_C)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [W-1:0] slot(input mat_t m, input int k);
    return m[(N-1-k)*W +: W];
  endfunction

  function automatic mat_t put(input mat_t m, input int k, input logic [W-1:0] v);
    mat_t r;
    r = m;
    r[(N-1-k)*W +: W] = v;
    return r;
  endfunction

  // C[i][j] = sum_m A[i][m]*B[m][j], element index i*4+j, truncated to W bits.
  function automatic mat_t matmul(input mat_t a, input mat_t b);
    mat_t r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        logic [W-1:0] acc;
        acc = '0;
        for (int m = 0; m < 4; m++) begin
          logic [2*W-1:0] p;
          p = slot(a, i*4+m) * slot(b, m*4+j);
          acc = acc + p[W-1:0];
        end
        r = put(r, i*4+j, acc);
      end
    end
    return r;
  endfunction

  function automatic mat_t rand_mat();
    mat_t r;
    r = '0;
    for (int k = 0; k < N; k++) r = put(r, k, W'($urandom));
    return r;
  endfunction

  // SIMD array model: recomputes the product on every enabled cycle.
  mat_t mc = '0;
  always @(posedge CLK) if (enable) mc <= matmul(Matrix_A, Matrix_B);
  assign Matrix_C = mc;

  task automatic check(input string tag, input mat_t got, input mat_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one element, with random idle cycles before it; returns at the negedge after transfer.
  task automatic send(input logic [W-1:0] d, input int gap_pct);
    int guard;
    guard = 0;
    while (int'($urandom_range(99)) < gap_pct) begin
      in_valid = 1'b0;
      in_data  = '1;
      @(negedge CLK);
    end
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(negedge CLK);
      guard++;
    end
    check("in_ready_wait", MW'(in_ready), MW'(1'b1));
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int stall_at);
    int idx, cyc, stall_n;
    logic [W-1:0] held;
    idx = 0; cyc = 0; stall_n = 0; held = '0;
    while (idx < N && cyc < 300) begin
      if (out_valid === 1'b1) begin
        if (idx == stall_at && stall_n < 5) begin
          out_ready = 1'b0;
          if (stall_n == 0) begin
            held = out_data;
          end else begin
            check("stall_data", MW'(out_data), MW'(held));
            check("stall_valid", MW'(out_valid), MW'(1'b1));
          end
          stall_n++;
        end else begin
          out_ready = 1'b1;
          check($sformatf("out_elem%0d", idx), MW'(out_data), MW'(sb.pop_front()));
          idx++;
        end
      end else begin
        out_ready = 1'b1;
      end
      @(negedge CLK);
      cyc++;
    end
    check("drain_count", MW'(idx), MW'(N));
  endtask

  task automatic run_job(input mat_t a, input mat_t b, input int gap_pct,
                         input int stall_at, input bit junk);
    mat_t c;
    int n;
    c = matmul(a, b);
    for (int k = 0; k < N; k++) sb.push_back(slot(c, k));
    for (int k = 0; k < N; k++) send(slot(a, k), gap_pct);
    for (int k = 0; k < N; k++) send(slot(b, k), gap_pct);
    check("compute_entry_en", MW'(enable), MW'(1'b1));
    check("compute_in_ready", MW'(in_ready), MW'(1'b0));
    check("mat_a_loaded", Matrix_A, a);
    check("mat_b_loaded", Matrix_B, b);
    if (junk) begin
      in_valid = 1'b1;
      in_data  = '1;
    end
    n = 0;
    while (enable === 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check("enable_cycles", MW'(n), MW'(LAT));
    check("capture_no_valid", MW'(out_valid), MW'(1'b0));
    drain(stall_at);
    check("mat_a_held", Matrix_A, a);
    check("mat_b_held", Matrix_B, b);
    in_valid = 1'b0;
    check("end_out_valid", MW'(out_valid), MW'(1'b0));
    check("end_busy", MW'(busy), MW'(1'b0));
    check("end_in_ready", MW'(in_ready), MW'(1'b1));
    check("sb_empty", MW'(sb.size()), MW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    mat_t ident, seq, ra, rb;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_in_ready", MW'(in_ready), MW'(1'b0));
    check("rst_out_valid", MW'(out_valid), MW'(1'b0));
    check("rst_enable", MW'(enable), MW'(1'b0));
    check("rst_busy", MW'(busy), MW'(1'b0));
    check("rst_out_data", MW'(out_data), MW'(0));
    check("rst_mat_a", Matrix_A, '0);
    reset = 1'b1;
    @(negedge CLK);
    check("in_ready_after_rst", MW'(in_ready), MW'(1'b1));

    ident = '0;
    seq   = '0;
    for (int k = 0; k < N; k++) begin
      ident = put(ident, k, (k / 4 == k % 4) ? W'(1) : W'(0));
      seq   = put(seq, k, W'(k + 1));
    end

    run_job(ident, seq, 0, -1, 1'b0);
    run_job(ident, seq, 50, -1, 1'b0);
    run_job(rand_mat(), rand_mat(), 0, 3, 1'b1);

    // Abandon a partial load with an asynchronous reset.
    for (int k = 0; k < 20; k++) send(W'($urandom), 0);
    #2 reset = 1'b0;
    #1;
    check("arst_in_ready", MW'(in_ready), MW'(1'b0));
    check("arst_busy", MW'(busy), MW'(1'b0));
    check("arst_enable", MW'(enable), MW'(1'b0));
    check("arst_out_valid", MW'(out_valid), MW'(1'b0));
    check("arst_out_data", MW'(out_data), MW'(0));
    check("arst_mat_a", Matrix_A, '0);
    check("arst_mat_b", Matrix_B, '0);
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    check("rerst_in_ready", MW'(in_ready), MW'(1'b1));

    ra = rand_mat();
    rb = rand_mat();
    run_job(ra, rb, 20, -1, 1'b0);
    run_job(rand_mat(), ra, 0, 5, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simd_stream_ctrl.md
SIMD_STREAM_CTRL -- requirements
Module: simd_stream_ctrl

Interface
REQ-001 SHALL have parameter ELEM_W, default 21, element width in bits.
REQ-002 SHALL have parameter LAT, default 2, SIMD compute cycles with enable held high (legal range 1..15).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  element available on in_data.
REQ-006 SHALL have port in_ready  output  1  block accepts an element this cycle.
REQ-007 SHALL have port in_data  input  ELEM_W  element stream: 16 A elements, then 16 B elements.
REQ-008 SHALL have port out_valid  output  1  result element available on out_data.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result element.
REQ-010 SHALL have port out_data  output  ELEM_W  result element stream, 16 C elements.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port Matrix_A  output  16*ELEM_W  packed A to the SIMD array.
REQ-013 SHALL have port Matrix_B  output  16*ELEM_W  packed B to the SIMD array.
REQ-014 SHALL have port enable  output  1  SIMD compute enable.
REQ-015 SHALL have port Matrix_C  input  16*ELEM_W  packed result from the SIMD array.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD_A, LOAD_B, COMPUTE, CAPTURE, DRAIN.
REQ-017 SHALL transfer an input element only on a cycle with in_valid and in_ready both high; in_ready high only in IDLE, LOAD_A and LOAD_B.
REQ-018 SHALL leave IDLE for LOAD_A on the first input transfer, and that element SHALL be A element 0.
REQ-019 SHALL store input element k (k=0..15) of a matrix at bits [16*ELEM_W-1-k*ELEM_W -: ELEM_W], i.e. element 0 in the MSB slot.
REQ-020 SHALL use a 4-bit element counter; on the transfer with count 15, it SHALL wrap to 0 and the state SHALL advance LOAD_A->LOAD_B or LOAD_B->COMPUTE.
REQ-021 SHALL hold Matrix_A and Matrix_B stable from entry to COMPUTE until the next input transfer.
REQ-022 SHALL drive enable high for exactly LAT consecutive cycles in COMPUTE, and low in all other states.
REQ-023 SHALL spend exactly one cycle in CAPTURE, registering Matrix_C into the result register at its end.
REQ-024 SHALL present result element k from the same slot mapping as REQ-019, MSB slot first, in DRAIN with out_valid high.
REQ-025 SHALL hold out_data stable while out_valid is high and out_ready is low.
REQ-026 SHALL advance the result element only on out_valid and out_ready both high; after element 15 is accepted it SHALL return to IDLE with out_valid low on the next cycle.
REQ-027 SHALL ignore in_valid outside IDLE/LOAD_A/LOAD_B, and ignore out_ready outside DRAIN.
REQ-028 SHALL tolerate in_valid gaps mid-load with no state or counter change.

Reset
REQ-029 SHALL, on reset low, immediately enter IDLE and clear counters, Matrix_A, Matrix_B and the result register to 0.
REQ-030 SHALL drive in_ready=0, out_valid=0, enable=0, busy=0 and out_data=0 while reset is low; in_ready SHALL go high on the first cycle after reset release.
REQ-031 SHALL abandon any partial load, compute or drain on reset assertion; no stale element SHALL be emitted after release.

Structure
REQ-032 SHALL take ELEM_W, the matrix element count 16 and the FSM state encoding from a shared package, simd_pkg.
REQ-033 SHALL use one sub-module, elem_shift_reg (parallel load, serial MSB-first unload), for the result register; the load path is inline.

Verification
REQ-034 SHALL cover: A=identity (1 on diagonal), B elements 1..16 with no gaps, out_ready=1 -> enable high for exactly 2 cycles, 16 outputs equal to the model product of the captured slots, in MSB-slot order.
REQ-035 SHALL cover: random in_valid gaps (50%) during load -> Matrix_A/Matrix_B identical to the gap-free case; COMPUTE entered one cycle after the 32nd transfer.
REQ-036 SHALL cover: out_ready held low for 5 cycles at element 3 -> out_data and out_valid unchanged throughout; element 4 follows the first accepting cycle.
REQ-037 SHALL cover: reset asserted after 20 input transfers -> all outputs 0 asynchronously; a fresh 32-element load then produces a correct result.
REQ-038 SHALL cover: in_valid=1 during COMPUTE/DRAIN with in_data=0x1FFFFF -> no transfer (in_ready=0), Matrix_A/Matrix_B unchanged.
REQ-039 SHALL cover: back-to-back jobs, with the next in_valid asserted on the cycle after the last output -> second job accepted from IDLE, result correct.
